// File: rtl/ct_f_spsram_arb_ctrl_if.sv
// rtl/ct_f_spsram_arb_ctrl_if.sv - requester, read-return and SRAM macro signals of the SRAM arbiter
interface ct_f_spsram_arb_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 92
);
  logic                  init_req;
  logic                  init_done;
  logic                  req0_vld;
  logic                  req0_wr;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [DATA_WIDTH-1:0] req0_wmask;
  logic                  req0_rdy;
  logic                  req1_vld;
  logic                  req1_wr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic [DATA_WIDTH-1:0] req1_wmask;
  logic                  req1_rdy;
  logic                  rd_vld;
  logic                  rd_id;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  init_req, req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
           req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask, sram_q,
    output init_done, req0_rdy, req1_rdy, rd_vld, rd_id, rd_data,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

  modport master (
    output init_req, req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
           req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask, sram_q,
    input  init_done, req0_rdy, req1_rdy, rd_vld, rd_id, rd_data,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );
endinterface

// File: rtl/ct_f_spsram_arb_ctrl.sv
// rtl/ct_f_spsram_arb_ctrl.sv - single-port SRAM clear sequencer and two-requester round-robin arbiter
module ct_f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 92,
  parameter int DEPTH      = 1024
) (
  input logic                   forever_cpuclk,
  input logic                   cpurst_b,
  ct_f_spsram_arb_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  rr_q;
  logic                  init_done_q;
  logic                  rd_vld_q;
  logic                  rd_id_q;

  logic                  run;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_any;
  logic                  gnt_wr;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [DATA_WIDTH-1:0] gnt_wmask;
  logic [ADDR_WIDTH-1:0] sram_a_d;
  logic [DATA_WIDTH-1:0] sram_d_d;
  logic                  sram_cen_d;
  logic                  sram_gwen_d;
  logic [DATA_WIDTH-1:0] sram_wen_d;

  always_comb begin
    run       = cpurst_b && (state_q == ST_RUN);
    gnt0      = run && bus.req0_vld && (!bus.req1_vld || !rr_q);
    gnt1      = run && bus.req1_vld && (!bus.req0_vld || rr_q);
    gnt_any   = gnt0 || gnt1;
    gnt_wr    = gnt1 ? bus.req1_wr    : bus.req0_wr;
    gnt_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    gnt_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    gnt_wmask = gnt1 ? bus.req1_wmask : bus.req0_wmask;

    // Idle keeps address/data parked on the last value so the macro pins do not toggle.
    sram_cen_d  = 1'b1;
    sram_gwen_d = 1'b1;
    sram_wen_d  = '1;
    sram_a_d    = a_q;
    sram_d_d    = d_q;
    if (cpurst_b && (state_q == ST_INIT)) begin
      sram_cen_d  = 1'b0;
      sram_gwen_d = 1'b0;
      sram_wen_d  = '0;
      sram_a_d    = cnt_q;
      sram_d_d    = '0;
    end else if (gnt_any) begin
      sram_cen_d = 1'b0;
      sram_a_d   = gnt_addr;
      sram_d_d   = gnt_wdata;
      if (gnt_wr) begin
        sram_gwen_d = 1'b0;
        sram_wen_d  = ~gnt_wmask;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      a_q         <= '0;
      d_q         <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_id_q     <= 1'b0;
    end else begin
      a_q      <= sram_a_d;
      d_q      <= sram_d_d;
      rd_vld_q <= gnt_any && !gnt_wr;
      if (gnt_any) begin
        rd_id_q <= gnt1;
        rr_q    <= ~gnt1;
      end
      case (state_q)
        ST_INIT: begin
          if (bus.init_req) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (bus.init_req) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.req0_rdy  = gnt0;
  assign bus.req1_rdy  = gnt1;
  assign bus.init_done = init_done_q;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_id     = rd_id_q;
  assign bus.rd_data   = bus.sram_q;
  assign bus.sram_a    = sram_a_d;
  assign bus.sram_d    = sram_d_d;
  assign bus.sram_cen  = sram_cen_d;
  assign bus.sram_gwen = sram_gwen_d;
  assign bus.sram_wen  = sram_wen_d;
endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// tb/tb_ct_f_spsram_arb_ctrl.sv - scoreboard bench for the SRAM clear sequencer and arbiter
module tb_ct_f_spsram_arb_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 92;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ct_f_spsram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rstn),
    .bus           (bus.slave)
  );

  // Behavioural macro: per-bit active-low write enables, Q registered one cycle after a read.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen)
        sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else
        bus.sram_q <= sram_mem[bus.sram_a];
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  rd_t           exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            run_exp = 1'b0;
  bit            rr_exp  = 1'b0;

  task automatic idle_inputs();
    bus.init_req   = 1'b0;
    bus.req0_vld   = 1'b0;
    bus.req0_wr    = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_wdata = '0;
    bus.req0_wmask = '0;
    bus.req1_vld   = 1'b0;
    bus.req1_wr    = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_wdata = '0;
    bus.req1_wmask = '0;
  endtask

  task automatic check_rd();
    rd_t e;
    n_tests++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (bus.rd_vld !== 1'b1 || bus.rd_id !== e.id || bus.rd_data !== e.data) begin
        n_fail++;
        $display("FAIL rd_return: vld=%0b id=%0b data=%h, required vld=1 id=%0b data=%h",
                 bus.rd_vld, bus.rd_id, bus.rd_data, e.id, e.data);
      end
    end else if (bus.rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_spurious: vld=%0b, required 0", bus.rd_vld);
    end
  endtask

  task automatic cycle(input bit v0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [DW-1:0] m1, input bit ir,
                       output logic o_rdy0, output logic o_vld, output logic o_id,
                       output logic [DW-1:0] o_data);
    logic g0, g1, sw;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd, sm;
    bus.req0_vld = v0; bus.req0_wr = w0; bus.req0_addr = a0; bus.req0_wdata = d0; bus.req0_wmask = m0;
    bus.req1_vld = v1; bus.req1_wr = w1; bus.req1_addr = a1; bus.req1_wdata = d1; bus.req1_wmask = m1;
    bus.init_req = ir;
    @(negedge clk);
    o_rdy0 = bus.req0_rdy;
    o_vld  = bus.rd_vld;
    o_id   = bus.rd_id;
    o_data = bus.rd_data;
    check_rd();
    if (run_exp) begin
      g0 = v0 && (!v1 || !rr_exp);
      g1 = v1 && (!v0 || rr_exp);
      n_tests++;
      if ({bus.req0_rdy, bus.req1_rdy} !== {g0, g1}) begin
        n_fail++;
        $display("FAIL grant: rdy0/rdy1=%b%b, required %b%b", bus.req0_rdy, bus.req1_rdy, g0, g1);
      end
      if (g0 || g1) begin
        sw = g1 ? w1 : w0; sa = g1 ? a1 : a0; sd = g1 ? d1 : d0; sm = g1 ? m1 : m0;
        n_tests++;
        if (bus.sram_cen !== 1'b0 || bus.sram_a !== sa || bus.sram_gwen !== !sw ||
            bus.sram_wen !== (sw ? ~sm : {DW{1'b1}}) || bus.sram_d !== sd) begin
          n_fail++;
          $display("FAIL sram_drive: cen=%b gwen=%b a=%h wen=%h, required cen=0 gwen=%b a=%h wen=%h",
                   bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_wen, !sw, sa,
                   sw ? ~sm : {DW{1'b1}});
        end
        if (sw) ref_mem[sa] = (ref_mem[sa] & ~sm) | (sd & sm);
        else    exp_q.push_back('{id: g1, data: ref_mem[sa]});
        rr_exp = g0;
      end else begin
        n_tests++;
        if (bus.sram_cen !== 1'b1 || bus.sram_gwen !== 1'b1 || bus.sram_wen !== {DW{1'b1}}) begin
          n_fail++;
          $display("FAIL sram_idle: cen=%b gwen=%b, required 1 1", bus.sram_cen, bus.sram_gwen);
        end
      end
      if (ir) begin
        run_exp = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Walk a full clear from counter 0, requesters hammering the whole time.
  task automatic check_init();
    int bad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.req0_vld = 1'b1;
      bus.req1_vld = 1'b1;
      @(negedge clk);
      check_rd();
      if (bus.sram_cen !== 1'b0 || bus.sram_gwen !== 1'b0 || bus.sram_wen !== '0 ||
          bus.sram_d !== '0 || bus.sram_a !== AW'(i) || bus.req0_rdy !== 1'b0 ||
          bus.req1_rdy !== 1'b0 || bus.init_done !== 1'b0) begin
        if (bad == 0) first = i;
        bad++;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL init_seq: %0d bad cycles, first at %0d, required 0 bad cycles", bad, first);
    end
    @(negedge clk);
    check_rd();
    n_tests++;
    if (bus.init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done: got %b, required 1", bus.init_done);
    end
    run_exp = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0_vld = 1'b1;
    bus.req1_vld = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.sram_cen !== 1'b1 || bus.sram_gwen !== 1'b1 || bus.sram_wen !== {DW{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_sram: cen=%b gwen=%b wen=%h, required 1 1 all-ones",
               bus.sram_cen, bus.sram_gwen, bus.sram_wen);
    end
    n_tests++;
    if ({bus.req0_rdy, bus.req1_rdy, bus.init_done, bus.rd_vld, bus.rd_id} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy0 rdy1 done vld id=%b, required 00000",
               {bus.req0_rdy, bus.req1_rdy, bus.init_done, bus.rd_vld, bus.rd_id});
    end
    @(posedge clk); #1;
    idle_inputs();
    exp_q.delete();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    rr_exp  = 1'b0;
    run_exp = 1'b0;
    rstn    = 1'b1;
    check_init();
  endtask

  task automatic test_round_robin();
    logic r0, v, id;
    logic [DW-1:0] d;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(1, 0, AW'(i + 1), '0, '0, 1, 0, AW'(i + 10), '0, '0, 0, r0, v, id, d);
      else       cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
      if (i < 4) begin
        n_tests++;
        if (r0 !== ((i % 2) == 0)) begin
          n_fail++;
          $display("FAIL rr_grant[%0d]: rdy0=%b, required %b", i, r0, (i % 2) == 0);
        end
      end
      if (i > 0) begin
        n_tests++;
        if (v !== 1'b1 || id !== 1'(((i - 1) % 2))) begin
          n_fail++;
          $display("FAIL rr_rd_id[%0d]: vld=%b id=%b, required 1 %0d", i, v, id, (i - 1) % 2);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic r0, v, id;
    logic [DW-1:0] d;
    cycle(1, 1, 10'h005, 92'h123, {DW{1'b1}}, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    cycle(1, 0, 10'h005, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    n_tests++;
    if (v !== 1'b1 || id !== 1'b0 || d !== 92'h123) begin
      n_fail++;
      $display("FAIL wr_rd_0x005: vld=%b id=%b data=%h, required 1 0 123", v, id, d);
    end
  endtask

  task automatic test_masked_write();
    logic r0, v, id;
    logic [DW-1:0] d;
    cycle(0, 0, '0, '0, '0, 1, 0, 10'h3FF, '0, '0, 0, r0, v, id, d);
    cycle(1, 1, 10'h3FF, 92'hFFF, 92'h00F, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    n_tests++;
    if (v !== 1'b1 || id !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL cleared_0x3ff: vld=%b id=%b data=%h, required 1 1 0", v, id, d);
    end
    cycle(1, 0, 10'h3FF, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    n_tests++;
    if (v !== 1'b1 || d !== 92'h00F) begin
      n_fail++;
      $display("FAIL masked_0x3ff: vld=%b data=%h, required 1 00f", v, d);
    end
  endtask

  task automatic test_init_req();
    logic r0, v, id;
    logic [DW-1:0] d;
    cycle(0, 0, '0, '0, '0, 1, 1, 10'h010, 92'hABCDE, {DW{1'b1}}, 0, r0, v, id, d);
    cycle(0, 0, '0, '0, '0, 1, 0, 10'h010, '0, '0, 1, r0, v, id, d);
    check_init();
    cycle(1, 0, 10'h010, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    cycle(0, 0, '0, '0, '0, 1, 0, 10'h005, '0, '0, 0, r0, v, id, d);
    n_tests++;
    if (v !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL reclear_0x010: vld=%b data=%h, required 1 0", v, d);
    end
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    n_tests++;
    if (v !== 1'b1 || id !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL reclear_0x005: vld=%b id=%b data=%h, required 1 1 0", v, id, d);
    end
  endtask

  task automatic test_reset_mid_init();
    logic r0, v, id;
    logic [DW-1:0] d;
    cycle(1, 1, 10'h020, 92'h5A5A, {DW{1'b1}}, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, r0, v, id, d);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check_rd();
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (bus.sram_a !== 10'd500 || bus.sram_cen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_cnt: a=%0d cen=%b, required 500 0", bus.sram_a, bus.sram_cen);
    end
    rstn = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (bus.sram_cen !== 1'b1 || bus.init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_reset: cen=%b done=%b, required 1 0", bus.sram_cen, bus.init_done);
    end
    @(posedge clk); #1;
    rstn    = 1'b1;
    rr_exp  = 1'b0;
    run_exp = 1'b0;
    check_init();
    cycle(1, 0, 10'h020, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, r0, v, id, d);
    n_tests++;
    if (v !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL after_reset_0x020: vld=%b data=%h, required 1 0", v, d);
    end
  endtask

  initial begin
    bus.sram_q = '0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_masked_write();
    test_init_req();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ct_f_spsram_arb_ctrl.md
Name: ct_f_spsram_arb_ctrl

Overview:
- Sequencing and sharing controller for one single-port FPGA SRAM macro (1024x92: active-low CEN/GWEN, per-bit active-low WEN, registered Q one cycle after access).
- After reset, or on request, it clears every entry to zero. It then arbitrates read and write accesses from two requesters round-robin and returns read data with a tagged valid.
- It sits between the cache/queue logic and the SRAM wrapper.

Parameters:
ADDR_WIDTH, 10, SRAM address width
DATA_WIDTH, 92, SRAM data width
DEPTH, 1024, number of entries cleared by INIT (must equal 2**ADDR_WIDTH)

Ports:
forever_cpuclk  in  1  clock; drives this block and the SRAM
cpurst_b  in  1  reset; synchronous, active-low
init_req  in  1  one-cycle pulse that restarts the clear sequence
init_done  out  1  high when the clear is finished and requests are accepted
req0_vld  in  1  requester 0 access valid
req0_wr  in  1  1 = write, 0 = read
req0_addr  in  ADDR_WIDTH  requester 0 address
req0_wdata  in  DATA_WIDTH  requester 0 write data
req0_wmask  in  DATA_WIDTH  requester 0 bit write enables, active-high
req0_rdy  out  1  requester 0 access accepted this cycle
req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask, req1_rdy  same as requester 0, for requester 1
rd_vld  out  1  read data valid
rd_id  out  1  requester that owns rd_data
rd_data  out  DATA_WIDTH  read data (SRAM Q passed through)
sram_a  out  ADDR_WIDTH  SRAM address
sram_cen  out  1  SRAM chip enable, active-low
sram_gwen  out  1  SRAM global write enable, active-low
sram_wen  out  DATA_WIDTH  SRAM bit write enables, active-low
sram_d  out  DATA_WIDTH  SRAM write data
sram_q  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset is checked on the rising edge of forever_cpuclk while cpurst_b=0. During reset: state=INIT, init counter=0, RR pointer=0, init_done=0, rd_vld=0, rd_id=0.
- Reset-time outputs: req*_rdy=0, sram_cen=1, sram_gwen=1, sram_wen all 1.
- States are INIT and RUN.
- INIT:
  - Each cycle drives sram_cen=0, sram_gwen=0, sram_wen=0, sram_d=0, sram_a=counter, then counter+1.
  - When counter==DEPTH-1 is written, go to RUN and clear the counter. INIT lasts exactly DEPTH cycles.
  - init_done is registered: it is 1 in the first RUN cycle and cleared the cycle after init_req is sampled.
  - req*_rdy=0 throughout INIT.
  - An init_req during INIT restarts the counter at 0.
- RUN grant logic (combinational in the same cycle):
  - Grant goes to the only valid requester. If both are valid, the grant goes to the requester selected by the RR pointer.
  - req*_rdy = grant. No grant when neither requester is valid.
  - After any grant, the RR pointer goes to the requester that was not granted. With no grant the pointer holds.
- RUN SRAM drive for the granted access:
  - sram_cen=0, sram_a=addr, sram_d=wdata.
  - Write: sram_gwen=0, sram_wen=~wmask.
  - Read: sram_gwen=1, sram_wen all 1.
  - With no grant: sram_cen=1, sram_gwen=1, sram_wen all 1. sram_a and sram_d are don't-care; hold them at the last value to save power.
- Read return:
  - A read granted in cycle N gives rd_vld=1, rd_id=granted id, and rd_data=sram_q in cycle N+1.
  - rd_vld is registered and lasts one cycle.
  - There is no back-pressure on read return; requesters must always sink it.
- Writes produce no response. Write-then-read to the same address in back-to-back cycles returns the new data, because the SRAM is sequential.
- init_req sampled in RUN:
  - Any access granted in that same cycle completes, including its read return.
  - The next state is INIT with counter=0.
  - No grants are made from the next cycle onward.
- Reset mid-INIT or mid-RUN takes effect at the next edge. Any pending rd_vld is dropped.
- sram_cen must never be low with an X address. All SRAM control outputs are fully defined in every state.

Test Plan:
- Release reset, no requests -> 1024 consecutive cycles of sram_cen=0, sram_gwen=0, sram_wen=0, sram_a 0..1023; init_done=1 on cycle 1025; req*_rdy stays 0 until then.
- After init, req0 writes addr 0x005 with data 0x123, mask all 1; the next cycle req0 reads 0x005 -> rd_vld=1, rd_id=0, rd_data=0x123 one cycle after the read grant.
- After init, req1 reads 0x3FF -> rd_data=0 (cleared). req0 writes 0x3FF with mask 0x00F and data 0xFFF, then reads it -> rd_data=0x00F.
- Both requesters hold vld=1 with reads for 4 cycles from reset pointer -> grants alternate 0,1,0,1 and rd_id follows 0,1,0,1.
- init_req pulses in the same cycle as a req1 read grant -> rd_vld for req1 follows in the next cycle; init_done=0 and INIT runs 1024 cycles; reading earlier-written addresses afterwards returns 0.
- Assert cpurst_b=0 at counter=500 during INIT -> after release, the clear restarts at addr 0 and runs the full 1024 cycles.
